filter_test_sequencer: RTL

//  Runs a programmed sweep of test-pulse delays through exp_sig_gen and v2_filter (inside filter).
//  Per step: drives test_overlay/test_rate/test_delay, waits a settle time, then measures the peak of
//  the filter output over a window. Returns each step's result over a valid/ready handshake.

---
 rtl/filter_test_sequencer_pkg.sv | 20 ++
 rtl/filter_test_sequencer_peak_detector.sv | 42 ++++
 rtl/filter_test_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/filter_test_sequencer_pkg.sv
// Shared settings for the filter test sequencer: default widths, settle time
// and the sequencer state encoding.
package filter_test_sequencer_pkg;

    localparam int SIZE_DELAY       = 8;
    localparam int SIZE_FILTER_DATA = 13;
    localparam int SIZE_STEP        = 8;
    localparam int SIZE_WINDOW      = 16;
    localparam int SETTLE_CYCLES    = 64;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SETUP,
        SEQ_SETTLE,
        SEQ_MEASURE,
        SEQ_REPORT,
        SEQ_FINISH
    } seq_state_t;

endpackage

// File: rtl/filter_test_sequencer_peak_detector.sv
// Running signed maximum of a sample stream plus the offset of its first
// occurrence. The first sample after clear seeds the maximum, so an all-negative
// window reports its true peak rather than zero.
module peak_detector #(
    parameter int DATA_W = 16,
    parameter int POS_W  = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic [POS_W-1:0]         pos_in,
    output logic signed [DATA_W-1:0] peak,
    output logic [POS_W-1:0]         peak_pos
);

    logic signed [DATA_W-1:0] peak_reg;
    logic [POS_W-1:0]         pos_reg;
    logic                     seeded_reg;

    // Track the maximum; only a strictly greater sample moves it, so ties keep the earliest offset.
    always_ff @(posedge clk) begin
        if (srst) begin
            peak_reg   <= '0;
            pos_reg    <= '0;
            seeded_reg <= 1'b0;
        end else if (clear) begin
            seeded_reg <= 1'b0;
        end else if (sample_en) begin
            seeded_reg <= 1'b1;
            if (!seeded_reg || (data_in > peak_reg)) begin
                peak_reg <= data_in;
                pos_reg  <= pos_in;
            end
        end
    end

    assign peak     = peak_reg;
    assign peak_pos = pos_reg;

endmodule

// File: rtl/filter_test_sequencer.sv
// Sweeps the exp_sig_gen test-pulse delay across a programmed number of steps.
// Each step restarts the generator, waits a fixed settle time, measures the peak
// of the v2_filter output over a window and hands the result out over valid/ready.
module filter_test_sequencer
    import filter_test_sequencer_pkg::*;
#(
    parameter int DELAY_W       = SIZE_DELAY,
    parameter int DATA_W        = SIZE_FILTER_DATA + 3,
    parameter int STEP_W        = SIZE_STEP,
    parameter int WIN_W         = SIZE_WINDOW,
    parameter int SETTLE_CYCLES = filter_test_sequencer_pkg::SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] cfg_delay_first,
    input  logic [DELAY_W-1:0] cfg_delay_incr,
    input  logic [STEP_W-1:0]  cfg_num_steps,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               cfg_overlay,
    input  logic [DATA_W-1:0]  filter_data,
    output logic               test_overlay,
    output logic               test_rate,
    output logic [DELAY_W-1:0] test_delay,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [STEP_W-1:0]  res_step,
    output logic [DELAY_W-1:0] res_delay,
    output logic [DATA_W-1:0]  res_peak,
    output logic [WIN_W-1:0]   res_peak_pos,
    output logic               busy,
    output logic               done
);

    localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t state_reg, state_next;

    logic [STEP_W-1:0]   step_reg;
    logic [STEP_W-1:0]   num_steps_reg;
    logic [DELAY_W-1:0]  delay_reg;
    logic [DELAY_W-1:0]  incr_reg;
    logic [DELAY_W-1:0]  test_delay_reg;
    logic [WIN_W-1:0]    window_last_reg;
    logic                overlay_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [WIN_W-1:0]    win_cnt_reg;

    logic latch_cfg;
    logic advance_step;
    logic last_step;

    logic signed [DATA_W-1:0] peak_value;
    logic [WIN_W-1:0]         peak_offset;

    assign last_step = (step_reg == (num_steps_reg - 1'b1));

    // Next-state selection, config/step strobes and all externally visible outputs.
    always_comb begin
        state_next   = state_reg;
        latch_cfg    = 1'b0;
        advance_step = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        test_rate    = 1'b0;
        test_overlay = overlay_reg;
        test_delay   = test_delay_reg;
        res_valid    = 1'b0;
        res_step     = '0;
        res_delay    = '0;
        res_peak     = '0;
        res_peak_pos = '0;

        case (state_reg)
            SEQ_IDLE: begin
                busy         = 1'b0;
                test_overlay = 1'b0;
                if (start && !abort) begin
                    latch_cfg  = 1'b1;
                    state_next = (cfg_num_steps == '0) ? SEQ_FINISH : SEQ_SETUP;
                end
            end
            SEQ_SETUP: begin
                // Rate held low for one cycle so the generator restarts on the new delay.
                state_next = SEQ_SETTLE;
            end
            SEQ_SETTLE: begin
                test_rate = 1'b1;
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = SEQ_MEASURE;
                end
            end
            SEQ_MEASURE: begin
                test_rate = 1'b1;
                if (win_cnt_reg == window_last_reg) begin
                    state_next = SEQ_REPORT;
                end
            end
            SEQ_REPORT: begin
                res_valid    = 1'b1;
                res_step     = step_reg;
                res_delay    = delay_reg;
                res_peak     = peak_value;
                res_peak_pos = peak_offset;
                if (res_ready) begin
                    if (last_step) begin
                        state_next = SEQ_FINISH;
                    end else begin
                        advance_step = 1'b1;
                        state_next   = SEQ_SETUP;
                    end
                end
            end
            SEQ_FINISH: begin
                done       = 1'b1;
                state_next = SEQ_IDLE;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase

        // Abort wins over everything except reset; a pending result is simply dropped.
        if (abort) begin
            state_next   = SEQ_IDLE;
            advance_step = 1'b0;
        end
    end

    // State register plus the step, delay, config and cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= SEQ_IDLE;
            step_reg        <= '0;
            num_steps_reg   <= '0;
            delay_reg       <= '0;
            incr_reg        <= '0;
            test_delay_reg  <= '0;
            window_last_reg <= '0;
            overlay_reg     <= 1'b0;
            settle_cnt_reg  <= '0;
            win_cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;

            if (latch_cfg) begin
                num_steps_reg   <= cfg_num_steps;
                incr_reg        <= cfg_delay_incr;
                window_last_reg <= (cfg_window == '0) ? '0 : (cfg_window - 1'b1);
                overlay_reg     <= cfg_overlay;
                step_reg        <= '0;
                delay_reg       <= cfg_delay_first;
                test_delay_reg  <= cfg_delay_first;
            end else if (advance_step) begin
                step_reg       <= step_reg + 1'b1;
                delay_reg      <= delay_reg + incr_reg;
                test_delay_reg <= delay_reg + incr_reg;
            end

            // Generator controls fall back to zero whenever the sweep ends.
            if (state_next == SEQ_IDLE) begin
                test_delay_reg <= '0;
                overlay_reg    <= 1'b0;
            end

            settle_cnt_reg <= (state_reg == SEQ_SETTLE)  ? (settle_cnt_reg + 1'b1) : '0;
            win_cnt_reg    <= (state_reg == SEQ_MEASURE) ? (win_cnt_reg + 1'b1)    : '0;
        end
    end

    peak_detector #(
        .DATA_W (DATA_W),
        .POS_W  (WIN_W)
    ) u_peak_detector (
        .clk       (clk),
        .srst      (reset),
        .clear     (state_reg == SEQ_SETUP),
        .sample_en (state_reg == SEQ_MEASURE),
        .data_in   ($signed(filter_data)),
        .pos_in    (win_cnt_reg),
        .peak      (peak_value),
        .peak_pos  (peak_offset)
    );

endmodule
